// File: rtl/gb_square_channel.sv
// gb_square_channel: Game Boy style pulse voice with frequency timer, duty sequencer,
// length counter, volume envelope and its own frame sequencer (no sweep).
module gb_square_channel #(
    parameter int FS_DIV = 2048
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        timer_tick,
    input  logic [1:0]  duty,
    input  logic [10:0] freq,
    input  logic [5:0]  length_load,
    input  logic        length_wr,
    input  logic        length_enable,
    input  logic [3:0]  env_init,
    input  logic        env_dir,
    input  logic [2:0]  env_period,
    input  logic        trigger,
    output logic [3:0]  level,
    output logic        active
);
    localparam int FW = FS_DIV > 1 ? $clog2(FS_DIV) : 1;
    localparam logic [FW-1:0] FS_LAST = FW'(FS_DIV - 1);

    logic [11:0]   ftimer_q, ftimer_d;
    logic [2:0]    step_q, step_d;
    logic [FW-1:0] fs_div_q, fs_div_d;
    logic [2:0]    fs_step_q, fs_step_d;
    logic [6:0]    length_ctr_q, length_ctr_d;
    logic [3:0]    volume_q, volume_d;
    logic [2:0]    env_timer_q, env_timer_d;
    logic          env_dir_q, env_dir_d;
    logic [2:0]    env_period_q, env_period_d;
    logic          active_q, active_d;
    logic [3:0]    level_q, level_d;

    logic        fs_wrap, len_clk, env_clk, len_dec, env_fire, step_adv;
    logic [6:0]  len_w;
    logic [2:0]  env_dec;
    logic [11:0] reload;
    logic [7:0]  pattern;

    always_comb begin
        fs_wrap      = timer_tick && fs_div_q == FS_LAST;
        fs_div_d     = fs_wrap ? '0 : fs_div_q + FW'(timer_tick);
        fs_step_d    = fs_step_q + 3'(fs_wrap);
        len_clk      = fs_wrap && !fs_step_d[0];
        env_clk      = fs_wrap && fs_step_d == 3'd7;
        reload       = 12'd2048 - {1'b0, freq};
        // a length write lands first so trigger's zero check sees the new value
        len_w        = length_wr ? 7'd64 - {1'b0, length_load} : length_ctr_q;
        len_dec      = !trigger && len_clk && length_enable && len_w != 7'd0;
        length_ctr_d = (trigger && len_w == 7'd0) ? 7'd64 : len_w - 7'(len_dec);
        active_d     = trigger ? (env_init != 4'd0 || env_dir)
                               : active_q && !(len_dec && len_w == 7'd1);
        env_dec      = env_timer_q - 3'd1;
        env_fire     = !trigger && env_clk && env_period_q != 3'd0;
        env_timer_d  = trigger ? env_period : !env_fire ? env_timer_q
                     : env_dec == 3'd0 ? env_period_q : env_dec;
        volume_d     = trigger ? env_init : !(env_fire && env_dec == 3'd0) ? volume_q
                     : env_dir_q ? volume_q + 4'(volume_q != 4'd15)
                     : volume_q - 4'(volume_q != 4'd0);
        env_dir_d    = trigger ? env_dir : env_dir_q;
        env_period_d = trigger ? env_period : env_period_q;
        step_adv     = !trigger && timer_tick && ftimer_q <= 12'd1;
        ftimer_d     = trigger ? reload : step_adv ? reload
                     : timer_tick ? ftimer_q - 12'd1 : ftimer_q;
        step_d       = step_q + 3'(step_adv);
        pattern      = duty == 2'd0 ? 8'b1000_0000 : duty == 2'd1 ? 8'b1000_0001
                     : duty == 2'd2 ? 8'b1110_0001 : 8'b0111_1110;
        level_d      = (active_d && pattern[step_d]) ? volume_d : 4'd0;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ftimer_q     <= '0;
            step_q       <= '0;
            fs_div_q     <= '0;
            fs_step_q    <= '0;
            length_ctr_q <= '0;
            volume_q     <= '0;
            env_timer_q  <= '0;
            env_dir_q    <= 1'b0;
            env_period_q <= '0;
            active_q     <= 1'b0;
            level_q      <= '0;
        end else begin
            ftimer_q     <= ftimer_d;
            step_q       <= step_d;
            fs_div_q     <= fs_div_d;
            fs_step_q    <= fs_step_d;
            length_ctr_q <= length_ctr_d;
            volume_q     <= volume_d;
            env_timer_q  <= env_timer_d;
            env_dir_q    <= env_dir_d;
            env_period_q <= env_period_d;
            active_q     <= active_d;
            level_q      <= level_d;
        end
    end

    assign level  = level_q;
    assign active = active_q;
endmodule

// File: tb/tb_gb_square_channel.sv
// tb_gb_square_channel: directed scenarios plus random stimulus, checked every cycle
// against a cycle-level behavioural model of the pulse voice.
module tb_gb_square_channel;
    localparam int FS = 16;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        timer_tick = 1'b0;
    logic [1:0]  duty = '0;
    logic [10:0] freq = '0;
    logic [5:0]  length_load = '0;
    logic        length_wr = 1'b0;
    logic        length_enable = 1'b0;
    logic [3:0]  env_init = '0;
    logic        env_dir = 1'b0;
    logic [2:0]  env_period = '0;
    logic        trigger = 1'b0;
    logic [3:0]  level;
    logic        active;

    always #5 clk = ~clk;

    gb_square_channel #(.FS_DIV(FS)) dut (
        .clk(clk), .reset_b(reset_b), .timer_tick(timer_tick), .duty(duty), .freq(freq),
        .length_load(length_load), .length_wr(length_wr), .length_enable(length_enable),
        .env_init(env_init), .env_dir(env_dir), .env_period(env_period), .trigger(trigger),
        .level(level), .active(active)
    );

    int vectors = 0, miscompares = 0;
    bit checking = 1'b0;
    logic [7:0] pats [4] = '{8'b1000_0000, 8'b1000_0001, 8'b1110_0001, 8'b0111_1110};
    int m_ft, m_step, m_fsd, m_fss, m_len, m_vol, m_et, m_per, m_lvl;
    bit m_dir, m_act;

    task automatic chk(string name, int got, int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ft = 0; m_step = 0; m_fsd = 0; m_fss = 0; m_len = 0;
        m_vol = 0; m_et = 0; m_per = 0; m_lvl = 0; m_dir = 0; m_act = 0;
    endtask

    task automatic model_step();
        bit lc = 0, ec = 0;
        if (timer_tick) begin
            m_fsd++;
            if (m_fsd == FS) begin
                m_fsd = 0;
                m_fss = (m_fss + 1) % 8;
                lc = (m_fss % 2 == 0);
                ec = (m_fss == 7);
            end
        end
        if (length_wr) m_len = 64 - int'(length_load);
        if (trigger) begin
            m_act = (env_init != 0) || env_dir;
            if (m_len == 0) m_len = 64;
            m_ft = 2048 - int'(freq);
            m_vol = int'(env_init);
            m_et = int'(env_period);
            m_per = int'(env_period);
            m_dir = env_dir;
        end else begin
            if (lc && length_enable && m_len > 0) begin
                m_len--;
                if (m_len == 0) m_act = 0;
            end
            if (ec && m_per != 0) begin
                m_et--;
                if (m_et == 0) begin
                    m_et = m_per;
                    if (m_dir) m_vol = (m_vol < 15) ? m_vol + 1 : 15;
                    else m_vol = (m_vol > 0) ? m_vol - 1 : 0;
                end
            end
            if (timer_tick) begin
                if (m_ft <= 1) begin
                    m_ft = 2048 - int'(freq);
                    m_step = (m_step + 1) % 8;
                end else m_ft--;
            end
        end
        m_lvl = (m_act && pats[duty][m_step]) ? m_vol : 0;
    endtask

    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("level", int'(level), m_lvl);
            chk("active", int'(active), int'(m_act));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic trig();
        trigger = 1'b1;
        cyc(1);
        trigger = 1'b0;
    endtask

    int exp1 [8] = '{15, 0, 0, 0, 0, 15, 15, 15};

    initial begin
        model_reset();
        cyc(3);
        checking = 1'b1;
        chk("reset_level", int'(level), 0);
        chk("reset_active", int'(active), 0);
        reset_b = 1'b1;
        cyc(2);

        // duty 10 with reload 4: four ticks per step
        duty = 2'd2; freq = 11'd2044; env_init = 4'd15; env_dir = 1'b0; env_period = 3'd0;
        trig();
        chk("t1_model_first", m_lvl, 15);
        timer_tick = 1'b1;
        for (int k = 0; k < 32; k++) begin
            chk("t1_level", int'(level), exp1[k/4]);
            cyc(1);
        end

        // length expiry after two length clocks
        timer_tick = 1'b0;
        length_load = 6'd62; length_wr = 1'b1;
        cyc(1);
        length_wr = 1'b0; length_enable = 1'b1; env_init = 4'd8;
        trig();
        chk("t2_active_on", int'(active), 1);
        chk("t2_model_len", m_len, 2);
        timer_tick = 1'b1;
        for (int n = 0; n < 2000 && active; n++) cyc(1);
        chk("t2_active_off", int'(active), 0);
        chk("t2_level_off", int'(level), 0);
        chk("t2_len_zero", int'(dut.length_ctr_q), 0);

        // trigger coinciding with a length clock while the counter is zero
        for (int n = 0; n < 400 && !(m_fsd == FS - 1 && (m_fss + 1) % 2 == 0); n++) cyc(1);
        trig();
        chk("t5_len_64", int'(dut.length_ctr_q), 64);
        chk("t5_model_len", m_len, 64);
        chk("t5_active", int'(active), 1);
        length_enable = 1'b0; length_load = 6'd10; length_wr = 1'b1; trigger = 1'b1;
        cyc(1);
        length_wr = 1'b0; trigger = 1'b0;
        chk("t5_len_54", int'(dut.length_ctr_q), 54);
        chk("t5_model_len54", m_len, 54);

        // envelope decay 3 -> 0 on successive fs_step 7 events
        timer_tick = 1'b0; duty = 2'd3;
        env_init = 4'd3; env_dir = 1'b0; env_period = 3'd1;
        trig();
        timer_tick = 1'b1;
        for (int e = 0; e < 3; e++) begin
            for (int n = 0; n < 300 && !(m_fsd == FS - 1 && m_fss == 6); n++) cyc(1);
            cyc(1);
            chk("t3_volume", int'(dut.volume_q), 2 - e);
            chk("t3_model_vol", m_vol, 2 - e);
        end
        cyc(FS * 8 + 4);
        chk("t3_volume_hold", int'(dut.volume_q), 0);
        chk("t3_active_hold", int'(active), 1);

        // DAC-off trigger, then DAC-on
        timer_tick = 1'b0; env_init = 4'd0; env_dir = 1'b0; env_period = 3'd0;
        trig();
        chk("t4_dac_off_active", int'(active), 0);
        chk("t4_dac_off_level", int'(level), 0);
        env_dir = 1'b1;
        trig();
        chk("t4_dac_on_active", int'(active), 1);

        // asynchronous reset mid-note
        env_init = 4'd15; env_dir = 1'b1; duty = 2'd3; freq = 11'd2046;
        trig();
        timer_tick = 1'b1;
        cyc(21);
        #2 reset_b = 1'b0;
        #1;
        chk("t6_level", int'(level), 0);
        chk("t6_active", int'(active), 0);
        chk("t6_step", int'(dut.step_q), 0);
        chk("t6_fs_step", int'(dut.fs_step_q), 0);
        @(posedge clk);
        #1 reset_b = 1'b1;
        cyc(40);
        chk("t6_silent_level", int'(level), 0);
        chk("t6_silent_active", int'(active), 0);

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            timer_tick = $urandom_range(0, 3) != 0;
            duty = 2'($urandom);
            freq = $urandom_range(0, 1) ? 11'($urandom_range(2036, 2047)) : 11'($urandom);
            length_load = 6'($urandom);
            length_wr = $urandom_range(0, 40) == 0;
            length_enable = $urandom_range(0, 3) != 0;
            env_init = 4'($urandom);
            env_dir = 1'($urandom);
            env_period = 3'($urandom);
            trigger = (n == 0) || $urandom_range(0, 60) == 0;
            cyc(1);
        end
        trigger = 1'b0; length_wr = 1'b0;
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
